// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM read sequencer: per-layer base/length lookup, credit-gated read issue
// into a registered-read SRAM, and a 2-entry skid FIFO streaming words to the PE array.

module weight_fetch_ctrl_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] fifo_cnt
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt == 2'd2)));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= 2'd2);
endmodule

module weight_fetch_ctrl #(
  parameter int WEIGHT_PER_ADDR = 9,
  parameter int BW_PER_PARAM    = 10,
  parameter int ADDR_BW         = 7
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [2:0]                              layer_id,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    sram_csb,
  output logic                                    sram_wsb,
  output logic [ADDR_BW-1:0]                      sram_raddr,
  input  logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0] sram_rdata,
  output logic                                    w_valid,
  input  logic                                    w_ready,
  output logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0] w_data,
  output logic [5:0]                              w_idx,
  output logic                                    w_last
);
  localparam int DW = WEIGHT_PER_ADDR * BW_PER_PARAM;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [ADDR_BW-1:0] layer_base(input logic [2:0] id);
    case (id)
      3'd0:    layer_base = ADDR_BW'(7'd0);
      3'd1:    layer_base = ADDR_BW'(7'd1);
      3'd2:    layer_base = ADDR_BW'(7'd10);
      3'd3:    layer_base = ADDR_BW'(7'd28);
      3'd4:    layer_base = ADDR_BW'(7'd37);
      3'd5:    layer_base = ADDR_BW'(7'd55);
      3'd6:    layer_base = ADDR_BW'(7'd64);
      3'd7:    layer_base = ADDR_BW'(7'd73);
      default: layer_base = ADDR_BW'(7'd0);
    endcase
  endfunction

  function automatic logic [5:0] layer_len(input logic [2:0] id);
    case (id)
      3'd0:    layer_len = 6'd1;
      3'd1:    layer_len = 6'd9;
      3'd2:    layer_len = 6'd18;
      3'd3:    layer_len = 6'd9;
      3'd4:    layer_len = 6'd18;
      3'd5:    layer_len = 6'd9;
      3'd6:    layer_len = 6'd9;
      3'd7:    layer_len = 6'd36;
      default: layer_len = 6'd1;
    endcase
  endfunction

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_BW-1:0] r_base;
  logic [5:0]         r_n;
  logic [5:0]         r_issue_cnt;
  logic [ADDR_BW-1:0] r_raddr_hold;
  logic               r_inflight;
  logic [5:0]         r_ret_idx;
  logic               r_ret_last;

  logic [DW-1:0]      r_fifo_data [2];
  logic [5:0]         r_fifo_idx  [2];
  logic               r_fifo_last [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_fifo_cnt;

  logic               w_accept;
  logic               w_pop;
  logic               w_push;
  logic [2:0]         w_credit;
  logic               w_issue;
  logic               w_last_issue;
  logic [ADDR_BW-1:0] w_addr;

  // Credit counts words already owned by the FIFO or in flight, net of this cycle's pop,
  // so a read goes out in the same cycle a full FIFO drains a slot.
  assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_pop        = w_valid && w_ready;
  assign w_push       = r_inflight;
  assign w_credit     = 3'(r_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_FETCH) && (w_credit < 3'd2);
  assign w_last_issue = (r_issue_cnt == (r_n - 6'd1));
  assign w_addr       = r_base + ADDR_BW'(r_issue_cnt);

  assign busy       = r_busy;
  assign done       = r_done;
  assign sram_wsb   = 1'b1;
  assign sram_csb   = ~w_issue;
  assign sram_raddr = w_issue ? w_addr : r_raddr_hold;
  assign w_valid    = (r_fifo_cnt != 2'd0);
  assign w_data     = r_fifo_data[r_rd_ptr];
  assign w_idx      = r_fifo_idx[r_rd_ptr];
  assign w_last     = r_fifo_last[r_rd_ptr];

  // Next-state selection for the fetch sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_FETCH;
        else          w_next_state = S_IDLE;
      end
      S_FETCH: begin
        if (w_issue && w_last_issue) w_next_state = S_DRAIN;
        else                         w_next_state = S_FETCH;
      end
      S_DRAIN: begin
        // Finished once nothing is in flight and this cycle's pop empties the FIFO.
        if (!r_inflight && (r_fifo_cnt == 2'(w_pop))) w_next_state = S_DONE;
        else                                          w_next_state = S_DRAIN;
      end
      S_DONE: begin
        if (w_accept) w_next_state = S_FETCH;
        else          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_FETCH) || (w_next_state == S_DRAIN);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Layer parameters, issue counter and held read address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= '0;
      r_n          <= 6'd0;
      r_issue_cnt  <= 6'd0;
      r_raddr_hold <= '0;
    end else begin
      if (w_accept) begin
        r_base      <= layer_base(layer_id);
        r_n         <= layer_len(layer_id);
        r_issue_cnt <= 6'd0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 6'd1;
      end
      if (w_issue) r_raddr_hold <= w_addr;
    end
  end

  // Tags for the read in flight; the SRAM data lands one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_ret_idx  <= 6'd0;
      r_ret_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_ret_idx  <= r_issue_cnt;
        r_ret_last <= w_last_issue;
      end
    end
  end

  // Two-entry skid FIFO; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= 6'd0;
        r_fifo_last[i] <= 1'b0;
      end
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= sram_rdata;
        r_fifo_idx[r_wr_ptr]  <= r_ret_idx;
        r_fifo_last[r_wr_ptr] <= r_ret_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  weight_fetch_ctrl_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .fifo_cnt (r_fifo_cnt)
  );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Randomized bench for weight_fetch_ctrl: SRAM behavioural model plus a transaction-level
// reference (expected address/word sequence per layer) checked every cycle.
module tb_weight_fetch_ctrl;
  localparam int DW = 90;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    layer_id;
  logic          busy;
  logic          done;
  logic          sram_csb;
  logic          sram_wsb;
  logic [6:0]    sram_raddr;
  logic [DW-1:0] sram_rdata;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic [5:0]    w_idx;
  logic          w_last;

  weight_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .layer_id   (layer_id),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_idx      (w_idx),
    .w_last     (w_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [109];
  int tab_base [8] = '{0, 1, 10, 28, 37, 55, 64, 73};
  int tab_n    [8] = '{1, 9, 18, 9, 18, 9, 9, 36};

  // Registered-read SRAM model
  always @(posedge clk) begin
    if (!sram_csb && (int'(sram_raddr) < 109)) sram_rdata <= mem[sram_raddr];
  end

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Reference model state (written only by the monitor)
  bit            m_active = 1'b0;
  bit            m_busy   = 1'b0;
  int            m_t = 0, m_base = 0, m_n = 0, m_issued = 0, m_popped = 0;
  int            m_done_at = -1;
  int            ready_mode = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [5:0]    prev_idx;
  logic          prev_last;

  always @(negedge clk) begin
    bit pop;
    bit exp_issue;
    int outst;
    if (rst) begin
      m_active   = 1'b0;
      m_busy     = 1'b0;
      m_done_at  = -1;
      prev_stall = 1'b0;
    end else begin
      pop   = w_valid && w_ready;
      outst = m_issued - m_popped;
      check_eq("busy", 128'(busy), 128'(m_busy));
      check_eq("done", 128'(done), 128'(cyc == m_done_at));
      check_eq("wsb", 128'(sram_wsb), 128'(1));
      if (m_active && (cyc > m_t) && (m_issued < m_n)) begin
        exp_issue = (outst - int'(pop)) < 2;
        check_eq("csb_issue", 128'(sram_csb), 128'(!exp_issue));
        if (!sram_csb) begin
          check_eq("raddr", 128'(sram_raddr), 128'(m_base + m_issued));
          m_issued++;
        end
      end else begin
        check_eq("csb_quiet", 128'(sram_csb), 128'(1));
      end
      if (m_active) check_eq("outstanding_le2", 128'(outst <= 2), 128'(1));
      else          check_eq("valid_idle", 128'(w_valid), 128'(0));
      if (prev_stall) begin
        check_eq("stall_valid", 128'(w_valid), 128'(1));
        check_eq("stall_data", 128'(w_data), 128'(prev_data));
        check_eq("stall_idx", 128'(w_idx), 128'(prev_idx));
        check_eq("stall_last", 128'(w_last), 128'(prev_last));
      end
      if (pop && m_active) begin
        check_eq("w_data", 128'(w_data), 128'(mem[m_base + m_popped]));
        check_eq("w_idx", 128'(w_idx), 128'(m_popped));
        check_eq("w_last", 128'(w_last), 128'(m_popped == m_n - 1));
        if (m_popped == 0 && ready_mode == 0) check_eq("first_valid_lat", 128'(cyc - m_t), 128'(3));
        m_popped++;
        if (m_popped == m_n) begin
          if (ready_mode == 0) check_eq("last_hs_lat", 128'(cyc - m_t), 128'(m_n + 2));
          m_active  = 1'b0;
          m_busy    = 1'b0;
          m_done_at = cyc + 1;
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_idx   = w_idx;
      prev_last  = w_last;
      if (start && !m_busy) begin
        m_active = 1'b1;
        m_busy   = 1'b1;
        m_t      = cyc;
        m_base   = tab_base[layer_id];
        m_n      = tab_n[layer_id];
        m_issued = 0;
        m_popped = 0;
      end
    end
  end

  // w_ready driver: 0 always high, 1 pattern 1,0,0,1, 2 random (mostly ready)
  initial begin
    int ph;
    ph = 0;
    w_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: begin
          w_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        2:       w_ready = ($urandom_range(0, 3) != 0);
        default: w_ready = 1'b1;
      endcase
    end
  end

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_busy"}, 128'(busy), 128'(0));
    check_eq({pfx, "_done"}, 128'(done), 128'(0));
    check_eq({pfx, "_csb"}, 128'(sram_csb), 128'(1));
    check_eq({pfx, "_wsb"}, 128'(sram_wsb), 128'(1));
    check_eq({pfx, "_raddr"}, 128'(sram_raddr), 128'(0));
    check_eq({pfx, "_valid"}, 128'(w_valid), 128'(0));
    check_eq({pfx, "_data"}, 128'(w_data), 128'(0));
    check_eq({pfx, "_idx"}, 128'(w_idx), 128'(0));
    check_eq({pfx, "_last"}, 128'(w_last), 128'(0));
  endtask

  task automatic pulse_start(input int id);
    @(posedge clk); #1;
    start    = 1'b1;
    layer_id = 3'(id);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_busy || m_active || (cyc <= m_done_at)) && (k < budget)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) check_eq("timeout_idle", 128'(0), 128'(1));
  endtask

  task automatic run_layer(input int id);
    pulse_start(id);
    wait_idle(600);
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    start    = 1'b0;
    layer_id = 3'd0;
    for (int i = 0; i < 109; i++) mem[i] = DW'({$urandom(), $urandom(), $urandom()});
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_layer(0);
    run_layer(7);

    ready_mode = 1;
    run_layer(2);
    ready_mode = 0;

    // start for layer 3 while layer 4 is in progress must be ignored
    pulse_start(4);
    repeat (6) @(posedge clk);
    #1;
    start    = 1'b1;
    layer_id = 3'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_idle(600);

    // back-to-back start in the DONE cycle
    pulse_start(1);
    k = 0;
    while ((cyc != m_done_at) && (k < 200)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check_eq("timeout_done", 128'(0), 128'(1));
    start    = 1'b1;
    layer_id = 3'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_idle(600);

    // reset in the middle of layer 7 after 10 handshakes
    ready_mode = 2;
    pulse_start(7);
    k = 0;
    while ((m_popped < 10) && (k < 400)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 400) check_eq("timeout_pops", 128'(0), 128'(1));
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    run_layer(6);

    for (int r = 0; r < 10; r++) begin
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_layer(int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
